// File: rtl/mat_operand_loader.sv
// Streaming operand loader: collects 2*N*N signed elements into two row-major NxN
// matrices and presents them to the compute unit with a valid/ready handshake.
module mat_operand_loader #(
    parameter int W_IN = 8,
    parameter int N    = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [W_IN-1:0]                  s_data,
    input  logic                             s_last,
    input  logic                             op_mode,
    output logic [N-1:0][N-1:0][W_IN-1:0]    matrix_1,
    output logic [N-1:0][N-1:0][W_IN-1:0]    matrix_2,
    output logic                             mode_o,
    output logic                             mat_valid,
    input  logic                             mat_ready,
    output logic                             err
);

    localparam int NN  = N * N;
    localparam int TOT = 2 * NN;
    localparam int CW  = $clog2(TOT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TOT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    logic [1:0]                      state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [N-1:0][N-1:0][W_IN-1:0]   mat1_q, mat1_d;
    logic [N-1:0][N-1:0][W_IN-1:0]   mat2_q, mat2_d;
    logic                            mode_q, mode_d;
    logic                            err_q, err_d;
    logic                            oor_q;
    logic                            beat;
    logic                            final_beat;

    // s_ready stays low for the first edge after reset release and throughout ISSUE
    assign s_ready    = (state_q != ST_ISSUE) && oor_q;
    assign beat       = s_valid && s_ready;
    assign final_beat = (cnt_q == CNT_LAST);

    assign matrix_1  = mat1_q;
    assign matrix_2  = mat2_q;
    assign mode_o    = mode_q;
    assign mat_valid = (state_q == ST_ISSUE);
    assign err       = err_q;

    always_comb begin
        mat1_d = mat1_q;
        mat2_d = mat2_q;
        if (beat) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (cnt_q == CW'(r * N + c)) begin
                        mat1_d[r][c] = s_data;
                    end
                    if (cnt_q == CW'(NN + r * N + c)) begin
                        mat2_d[r][c] = s_data;
                    end
                end
            end
        end
    end

    // Any s_last that does not coincide with the final beat, or a final beat
    // without s_last, abandons the frame and reports a framing error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    mode_d = op_mode;
                    if (s_last) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (final_beat && s_last) begin
                        state_d = ST_ISSUE;
                    end else if (final_beat || s_last) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_ISSUE: begin
                if (mat_ready) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mat1_q  <= '0;
            mat2_q  <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mat1_q  <= mat1_d;
            mat2_q  <= mat2_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            oor_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Scoreboard bench for mat_operand_loader: frames are pushed as expected issues or
// framing errors; an independent monitor pops and checks them as the DUT responds.
`timescale 1ns/1ps
module tb_mat_operand_loader;

    localparam int W_IN = 8;
    localparam int N    = 2;
    localparam int NN   = N * N;
    localparam int TOT  = 2 * NN;

    typedef logic [N-1:0][N-1:0][W_IN-1:0] mat_t;
    typedef struct {
        bit   is_err;
        mat_t m1;
        mat_t m2;
        bit   mode;
        int   cyc;
    } exp_t;

    logic            clk       = 1'b0;
    logic            rstn      = 1'b0;
    logic            s_valid   = 1'b0;
    logic            s_last    = 1'b0;
    logic            op_mode   = 1'b0;
    logic            mat_ready = 1'b0;
    logic [W_IN-1:0] s_data    = '0;
    logic            s_ready;
    logic            mode_o;
    logic            mat_valid;
    logic            err;
    mat_t            matrix_1;
    mat_t            matrix_2;

    exp_t exp_q[$];
    int   n_vec       = 0;
    int   n_miss      = 0;
    int   cyc         = 0;
    int   rdy_policy  = 0;
    int   expect_hold = 0;
    bit   gap_en      = 0;
    bit   gap_check   = 0;
    int   last_rise   = -1;
    bit   tracking    = 0;

    mat_operand_loader #(.W_IN(W_IN), .N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .op_mode   (op_mode),
        .matrix_1  (matrix_1),
        .matrix_2  (matrix_2),
        .mode_o    (mode_o),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_event(input string name, input string got, input string want);
        n_vec++;
        n_miss++;
        $display("[TB] FAIL %s: got %s, expected %s (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic check_operands(input exp_t e);
        checkOutput("matrix_1", 64'(matrix_1), 64'(e.m1));
        checkOutput("matrix_2", 64'(matrix_2), 64'(e.m2));
        checkOutput("mode_o", 64'(mode_o), 64'(e.mode));
        checkOutput("s_ready_in_issue", 64'(s_ready), 64'(0));
        checkOutput("err_in_issue", 64'(err), 64'(0));
    endtask

    // mat_ready policy: 0 always ready, 1 random, 2 low for the first 3 valid cycles
    initial begin : ready_drv
        int vcnt;
        vcnt = 0;
        forever begin
            @(negedge clk);
            vcnt = mat_valid ? vcnt + 1 : 0;
            case (rdy_policy)
                0:       mat_ready = 1'b1;
                1:       mat_ready = 1'($urandom_range(0, 1));
                default: mat_ready = (vcnt >= 4);
            endcase
        end
    end

    initial begin : monitor
        exp_t cur;
        exp_t it;
        int   hold;
        bit   xfer_pending;
        bit   handled;
        hold = 0;
        xfer_pending = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                tracking     = 0;
                xfer_pending = 0;
            end else begin
                handled = 0;
                if (tracking) begin
                    handled = 1;
                    if (xfer_pending) begin
                        checkOutput("valid_after_xfer", 64'(mat_valid), 64'(0));
                        checkOutput("s_ready_after_xfer", 64'(s_ready), 64'(1));
                        if (expect_hold > 0)
                            checkOutput("hold_cycles", 64'(hold), 64'(expect_hold));
                        tracking     = 0;
                        xfer_pending = 0;
                    end else if (!mat_valid) begin
                        fail_event("valid_dropped", "mat_valid=0", "held until mat_ready");
                        tracking = 0;
                    end else begin
                        check_operands(cur);
                        hold++;
                        xfer_pending = mat_ready;
                    end
                end
                if (!handled) begin
                    if (mat_valid || err) begin
                        if (exp_q.size() == 0) begin
                            fail_event(mat_valid ? "unexpected_valid" : "unexpected_err",
                                       "event", "nothing");
                        end else begin
                            it = exp_q.pop_front();
                            checkOutput("event_latency", 64'(cyc), 64'(it.cyc + 1));
                            checkOutput("err_flag", 64'(err), 64'(it.is_err));
                            checkOutput("valid_flag", 64'(mat_valid), 64'(!it.is_err));
                            if (mat_valid && !it.is_err) begin
                                check_operands(it);
                                cur          = it;
                                tracking     = 1;
                                hold         = 1;
                                xfer_pending = mat_ready;
                                if (gap_check) begin
                                    if (last_rise >= 0)
                                        checkOutput("issue_spacing", 64'(cyc - last_rise), 64'(TOT + 1));
                                    last_rise = cyc;
                                end
                            end
                        end
                    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 1) begin
                        fail_event(exp_q[0].is_err ? "missing_err" : "missing_valid", "no event", "event");
                        it = exp_q.pop_front();
                    end
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = W_IN'($urandom);
        end
    endtask

    task automatic send_beat(input logic [W_IN-1:0] d, input bit last, input bit mode,
                             output int acc, output bit ok);
        bit rd;
        ok  = 0;
        acc = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last;
            op_mode = mode;
            rd      = s_ready;
            acc     = cyc;
            @(posedge clk);
            ok = rd;
        end
        if (!ok) fail_event("s_ready_timeout", "s_ready low 200 cycles", "beat accepted");
    endtask

    // last_at = TOT-1 is a correct frame; smaller stops the frame early; TOT omits s_last
    task automatic applyStimulus(input logic [W_IN-1:0] e[TOT], input bit mode, input int last_at);
        exp_t x;
        int   acc;
        bit   ok;
        int   n_beats;
        acc = 0;
        n_beats = (last_at < TOT - 1) ? last_at + 1 : TOT;
        for (int i = 0; i < n_beats; i++) begin
            if (gap_en && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            send_beat(e[i], (i == last_at), (i == 0) ? mode : 1'($urandom), acc, ok);
            if (!ok) return;
        end
        x.is_err = (last_at != TOT - 1);
        x.mode   = mode;
        x.cyc    = acc;
        x.m1     = '0;
        x.m2     = '0;
        for (int i = 0; i < NN; i++) begin
            x.m1[i / N][i % N] = e[i];
            x.m2[i / N][i % N] = e[NN + i];
        end
        exp_q.push_back(x);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
        checkOutput("rst_mat_valid", 64'(mat_valid), 64'(0));
        checkOutput("rst_err", 64'(err), 64'(0));
        checkOutput("rst_mode_o", 64'(mode_o), 64'(0));
        checkOutput("rst_matrix_1", 64'(matrix_1), 64'(0));
        checkOutput("rst_matrix_2", 64'(matrix_2), 64'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("s_ready_at_release", 64'(s_ready), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("s_ready_after_edge", 64'(s_ready), 64'(1));
    endtask

    initial begin : main
        logic [W_IN-1:0] e[TOT];
        int acc;
        bit ok;
        int r;
        acc = 0;
        ok  = 0;

        apply_reset();

        $display("[TB] basic multiply");
        rdy_policy  = 0;
        expect_hold = 1;
        for (int i = 0; i < TOT; i++) e[i] = W_IN'(i + 1);
        applyStimulus(e, 1'b0, TOT - 1);
        idle_cycles(4);

        $display("[TB] backpressure and add mode");
        rdy_policy  = 2;
        expect_hold = 4;
        e[0] = 8'h80; e[1] = 8'h7f; e[2] = 8'hff; e[3] = 8'h00;
        e[4] = 8'h05; e[5] = 8'hfb; e[6] = 8'h02; e[7] = 8'h03;
        applyStimulus(e, 1'b1, TOT - 1);
        idle_cycles(8);

        $display("[TB] early s_last");
        rdy_policy  = 0;
        expect_hold = 1;
        for (int i = 0; i < TOT; i++) e[i] = W_IN'($urandom);
        applyStimulus(e, 1'b0, 4);
        idle_cycles(2);
        for (int i = 0; i < TOT; i++) e[i] = W_IN'(11 + i);
        applyStimulus(e, 1'b0, TOT - 1);
        idle_cycles(4);

        $display("[TB] s_last on beat 0");
        applyStimulus(e, 1'b1, 0);
        idle_cycles(3);

        $display("[TB] missing s_last");
        for (int i = 0; i < TOT; i++) e[i] = W_IN'($urandom);
        applyStimulus(e, 1'b1, TOT);
        for (int i = 0; i < TOT; i++) e[i] = W_IN'(21 + i);
        applyStimulus(e, 1'b1, TOT - 1);
        idle_cycles(4);

        $display("[TB] reset mid-load");
        send_beat(8'hc1, 1'b0, 1'b1, acc, ok);
        send_beat(8'hc2, 1'b0, 1'b1, acc, ok);
        send_beat(8'hc3, 1'b0, 1'b1, acc, ok);
        apply_reset();
        for (int i = 0; i < TOT; i++) e[i] = W_IN'(31 + i);
        applyStimulus(e, 1'b0, TOT - 1);
        idle_cycles(4);

        $display("[TB] back-to-back throughput");
        gap_check = 1;
        last_rise = -1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < TOT; i++) e[i] = W_IN'($urandom);
            applyStimulus(e, 1'(f % 2), TOT - 1);
        end
        idle_cycles(4);
        gap_check = 0;

        $display("[TB] randomized frames");
        gap_en      = 1;
        rdy_policy  = 1;
        expect_hold = 0;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < TOT; i++) e[i] = W_IN'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, TOT - 1);
                applyStimulus(e, 1'($urandom), (r == TOT - 1) ? TOT : r);
            end else begin
                applyStimulus(e, 1'($urandom), TOT - 1);
            end
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 4));
        end

        idle_cycles(1);
        for (int t = 0; t < 300 && (exp_q.size() != 0 || tracking); t++) @(negedge clk);
        if (exp_q.size() != 0)
            fail_event("drain", "pending expectations", "queue empty");
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
